motor_gate_guard: RTL

- N-phase half-bridge gate interlock between the commutation/PWM logic and the gate-drive pins of the motor602 design.
- Enforces per-phase dead-time, detects illegal gate requests (shoot-through, all high-sides on), latches a fault and forces every bridge to the safe state until the fault is cleared.
- Generalises the fixed 3-phase pattern checks in the motor602 bench into synthesizable, parametrised protection.

---
 rtl/motor602_pkg.sv | 53 +++++
 rtl/motor_gate_guard_phase.sv | 142 ++++++++++++++
 rtl/motor_gate_guard.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/motor602_pkg.sv
// -----------------------------------------------------------------------------
// motor602_pkg
// Shared types and constants for the motor602 gate interlock:
//   - phase_state_e : per-phase half-bridge state (OFF, HI, LO, DH, DL)
//   - fault_state_e : bridge-level fault state (RUN, FAULT)
//   - req_e         : decoded per-phase gate request
//   - FC_*          : fault code values reported on faultCodeO
//   - SAFE_HP/LN    : gate levels that switch both devices of a half-bridge off
//   - decode_req()  : maps the raw (active-low hp, active-high ln) pair to req_e
// -----------------------------------------------------------------------------
package motor602_pkg;

    typedef enum logic [2:0] {
        PH_OFF = 3'd0,
        PH_HI  = 3'd1,
        PH_LO  = 3'd2,
        PH_DH  = 3'd3,
        PH_DL  = 3'd4
    } phase_state_e;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fault_state_e;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_HI   = 2'd1,
        REQ_LO   = 2'd2,
        REQ_BOTH = 2'd3
    } req_e;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_SHOOT = 2'd1;
    localparam logic [1:0] FC_ALLHI = 2'd2;
    localparam logic [1:0] FC_EXT   = 2'd3;

    // High-side gate is a P-device (off when high), low-side is an N-device.
    localparam logic SAFE_HP = 1'b1;
    localparam logic SAFE_LN = 1'b0;

    function automatic req_e decode_req(input logic hp_req, input logic ln_req);
        req_e r;
        case ({hp_req, ln_req})
            2'b00:   r = REQ_HI;
            2'b11:   r = REQ_LO;
            2'b10:   r = REQ_NONE;
            default: r = REQ_BOTH;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/motor_gate_guard_phase.sv
// -----------------------------------------------------------------------------
// motor_gate_phase
// One half-bridge: request decode, OFF/HI/LO/DH/DL state machine and the
// dead-time counter. Outputs are registered from the next state.
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset (phase goes OFF at once)
//   force_safe_i   bridge disabled or fault latched/detected: drop any
//                  conducting side into dead-time, block every turn-on
//   hp_req_i       high-side request, active-low
//   ln_req_i       low-side request, active-high
//   hp_o           high-side gate, active-low
//   ln_o           low-side gate, active-high
//   dead_busy_o    phase is in DH or DL
// -----------------------------------------------------------------------------
module motor_gate_phase
    import motor602_pkg::*;
#(
    parameter int DEAD_CYC = 50,
    parameter int CW       = $clog2(DEAD_CYC + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic force_safe_i,
    input  logic hp_req_i,
    input  logic ln_req_i,
    output logic hp_o,
    output logic ln_o,
    output logic dead_busy_o
);

    localparam int             CWP1      = CW + 1;
    localparam logic [CW:0]    DEAD_LAST = CWP1'(DEAD_CYC - 1);
    localparam logic [CW:0]    ONE_W     = CWP1'(1);
    localparam logic [CW-1:0]  ONE_C     = CW'(1);

    phase_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hp_q, hp_d;
    logic          ln_q, ln_d;
    logic          busy_q, busy_d;
    req_e          req_s;
    logic          dead_done_s;

    assign req_s = decode_req(hp_req_i, ln_req_i);

    // The dead phase ends when the incremented count reaches DEAD_CYC-1; the
    // OFF cycle that follows completes the DEAD_CYC-cycle gap before the
    // opposite device may turn on.
    assign dead_done_s = (({1'b0, cnt_q}) + ONE_W) >= DEAD_LAST;

    // Next-state, dead-time counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PH_OFF: begin
                if (!force_safe_i && (req_s == REQ_HI)) begin
                    state_d = PH_HI;
                end else if (!force_safe_i && (req_s == REQ_LO)) begin
                    state_d = PH_LO;
                end else begin
                    state_d = PH_OFF;
                end
            end
            PH_HI: begin
                if (force_safe_i || (req_s != REQ_HI)) begin
                    state_d = PH_DH;
                    cnt_d   = '0;
                end else begin
                    state_d = PH_HI;
                end
            end
            PH_LO: begin
                if (force_safe_i || (req_s != REQ_LO)) begin
                    state_d = PH_DL;
                    cnt_d   = '0;
                end else begin
                    state_d = PH_LO;
                end
            end
            PH_DH: begin
                // Re-enabling the device that just switched off needs no gap.
                if (!force_safe_i && (req_s == REQ_HI)) begin
                    state_d = PH_HI;
                end else if (dead_done_s) begin
                    state_d = PH_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            PH_DL: begin
                if (!force_safe_i && (req_s == REQ_LO)) begin
                    state_d = PH_LO;
                end else if (dead_done_s) begin
                    state_d = PH_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = PH_OFF;
                cnt_d   = '0;
            end
        endcase

        hp_d   = SAFE_HP;
        ln_d   = SAFE_LN;
        busy_d = 1'b0;
        case (state_d)
            PH_HI:   hp_d   = 1'b0;
            PH_LO:   ln_d   = 1'b1;
            PH_DH:   busy_d = 1'b1;
            PH_DL:   busy_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // State, counter and gate output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= PH_OFF;
            cnt_q   <= '0;
            hp_q    <= SAFE_HP;
            ln_q    <= SAFE_LN;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            ln_q    <= ln_d;
            busy_q  <= busy_d;
        end
    end

    assign hp_o        = hp_q;
    assign ln_o        = ln_q;
    assign dead_busy_o = busy_q;

endmodule

// File: rtl/motor_gate_guard.sv
// -----------------------------------------------------------------------------
// motor_gate_guard
// N-phase half-bridge gate interlock: per-phase dead-time (motor_gate_phase),
// illegal-request detection, latched fault with minimum hold and clear.
// Optional build macro: MOTOR_GATE_GUARD_FAULT_CNT_EN adds faultCntO, an
// 8-bit saturating count of RUN->FAULT entries cleared only by nRstI.
// Ports:
//   clk50mhzI    50 MHz clock
//   nRstI        synchronous reset, active-low
//   enI          bridge enable (0 = all phases safe, no fault)
//   hpReqI       high-side requests, active-low
//   lnReqI       low-side requests, active-high
//   faultI       external fault, already synchronised
//   faultClrI    fault clear request, level
//   hpO / lnO    gate drives (active-low / active-high)
//   faultO       fault latched
//   faultCodeO   0 none, 1 shoot-through, 2 all high-sides, 3 external
//   faultPhaseO  phases that requested shoot-through at detection
//   deadBusyO    phase in dead-time
// -----------------------------------------------------------------------------
module motor_gate_guard
    import motor602_pkg::*;
#(
    parameter int PHASES     = 3,
    parameter int DEAD_CYC   = 50,
    parameter int FAULT_HOLD = 5000,
    parameter int CW         = $clog2(DEAD_CYC + 1)
) (
    input  logic              clk50mhzI,
    input  logic              nRstI,
    input  logic              enI,
    input  logic [PHASES-1:0] hpReqI,
    input  logic [PHASES-1:0] lnReqI,
    input  logic              faultI,
    input  logic              faultClrI,
    output logic [PHASES-1:0] hpO,
    output logic [PHASES-1:0] lnO,
    output logic              faultO,
    output logic [1:0]        faultCodeO,
    output logic [PHASES-1:0] faultPhaseO,
    output logic [PHASES-1:0] deadBusyO
`ifdef MOTOR_GATE_GUARD_FAULT_CNT_EN
,   output logic [7:0]        faultCntO
`endif
);

    localparam int            HW       = (FAULT_HOLD < 1) ? 1 : $clog2(FAULT_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(FAULT_HOLD);
    localparam logic [HW-1:0] ONE_H    = HW'(1);

    fault_state_e      fstate_q, fstate_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [1:0]        code_q, code_d;
    logic [PHASES-1:0] fphase_q, fphase_d;
    logic              fault_q, fault_d;

    logic [PHASES-1:0] both_s;
    logic [PHASES-1:0] none_s;
    logic              shoot_s;
    logic              allhi_s;
    logic              detect_s;
    logic              force_s;
    logic              clr_ok_s;

    assign both_s   = ~hpReqI & lnReqI;
    assign none_s   = hpReqI & ~lnReqI;
    assign shoot_s  = |both_s;
    assign allhi_s  = ~|hpReqI;
    assign detect_s = enI & (fstate_q == FS_RUN) & (faultI | shoot_s | allhi_s);
    // Detection forces the phases in the same edge that latches the fault,
    // so a request change coinciding with the detect never reaches a gate.
    assign force_s  = ~enI | (fstate_q == FS_FAULT) | detect_s;
    assign clr_ok_s = (hold_q == HOLD_MAX) & faultClrI & ~faultI & (&none_s);

    // Fault FSM: capture code/phase on entry, saturating hold count, clear.
    always_comb begin
        fstate_d = fstate_q;
        hold_d   = hold_q;
        code_d   = code_q;
        fphase_d = fphase_q;
        case (fstate_q)
            FS_RUN: begin
                if (detect_s) begin
                    fstate_d = FS_FAULT;
                    hold_d   = ONE_H;
                    if (faultI) begin
                        code_d   = FC_EXT;
                        fphase_d = '0;
                    end else if (shoot_s) begin
                        code_d   = FC_SHOOT;
                        fphase_d = both_s;
                    end else begin
                        code_d   = FC_ALLHI;
                        fphase_d = '0;
                    end
                end else begin
                    fstate_d = FS_RUN;
                end
            end
            FS_FAULT: begin
                if (clr_ok_s) begin
                    fstate_d = FS_RUN;
                    hold_d   = '0;
                    code_d   = FC_NONE;
                    fphase_d = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + ONE_H;
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                fstate_d = FS_FAULT;
            end
        endcase
        fault_d = (fstate_d == FS_FAULT);
    end

    // Fault state and reported-code registers.
    always_ff @(posedge clk50mhzI) begin
        if (!nRstI) begin
            fstate_q <= FS_RUN;
            hold_q   <= '0;
            code_q   <= FC_NONE;
            fphase_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            fstate_q <= fstate_d;
            hold_q   <= hold_d;
            code_q   <= code_d;
            fphase_q <= fphase_d;
            fault_q  <= fault_d;
        end
    end

    assign faultO      = fault_q;
    assign faultCodeO  = code_q;
    assign faultPhaseO = fphase_q;

`ifdef MOTOR_GATE_GUARD_FAULT_CNT_EN
    logic [7:0] fcnt_q, fcnt_d;

    // Saturating count of fault entries.
    always_comb begin
        if (detect_s && (fcnt_q != 8'hFF)) begin
            fcnt_d = fcnt_q + 8'd1;
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Fault entry counter register.
    always_ff @(posedge clk50mhzI) begin
        if (!nRstI) begin
            fcnt_q <= 8'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign faultCntO = fcnt_q;
`endif

    for (genvar p = 0; p < PHASES; p++) begin : g_phase
        motor_gate_phase #(
            .DEAD_CYC (DEAD_CYC),
            .CW       (CW)
        ) u_phase (
            .clk_i        (clk50mhzI),
            .rst_ni       (nRstI),
            .force_safe_i (force_s),
            .hp_req_i     (hpReqI[p]),
            .ln_req_i     (lnReqI[p]),
            .hp_o         (hpO[p]),
            .ln_o         (lnO[p]),
            .dead_busy_o  (deadBusyO[p])
        );
    end

endmodule
